dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
// - Arbitrates two requesters for the single-port 128x32 data memory: port 0 = MEM-stage load/store,
//   port 1 = loader/debug master. One access in flight at a time.
// - Sequences each access (address/strobe drive, programmable wait states, read-data capture) and
//   returns a one-cycle done pulse; the pipeline stalls on req0_valid & ~done0.
// PARAMETERS
// - ADDR_W       9   byte address width (word index = addr[ADDR_W-1:2])
// - DATA_W       32  data width
// - WAIT_CYCLES  0   extra ACCESS cycles per access, legal 0..15
// - CNT_W        4   wait counter width, must hold WAIT_CYCLES
// PORTS
// - clk        in   1       rising-edge clock
// - rst_n      in   1       asynchronous active-low reset
// - req0_valid in   1       port 0 request; held with its payload until done0
// - req0_we    in   1       1 = write, 0 = read
// - req0_addr  in   ADDR_W  byte address
// - req0_wdata in   DATA_W  write data
// - done0      out  1       one-cycle completion pulse
// - rdata0     out  DATA_W  read data, valid while done0=1, else 0
// - err0       out  1       misaligned access, valid while done0=1
// - req1_*, done1, rdata1, err1: identical set for port 1
// - mem_addr   out  ADDR_W  to memory MemAddr
// - mem_read   out  1       to memory MemRead
// - mem_write  out  1       to memory MemWrite
// - mem_wdata  out  DATA_W  to memory Write_Data
// - mem_rdata  in   DATA_W  from memory Read_Data
// - busy       out  1       state != IDLE
// BEHAVIOUR
// - Reset: state=IDLE, all outputs 0, counter 0, last_grant=1; asynchronous assertion, sync release.
// - FSM IDLE: if any valid, grant winner, latch owner/we/addr/wdata, cnt<=WAIT_CYCLES -> ACCESS.
// - ACCESS: mem_addr=latched addr; read: mem_read=1 every ACCESS cycle; write: mem_write=1 only in the
//   first ACCESS cycle; mem_read/mem_write never both 1, both 0 outside ACCESS.
//   cnt==0 -> capture mem_rdata into rdata reg, go RESP; else cnt<=cnt-1.
// - RESP: done<owner>=1 for exactly one cycle with rdata/err; -> IDLE. No back-to-back grant: the
//   earliest next grant is the IDLE cycle after RESP.
// - Latency: valid sampled at edge k; ACCESS occupies 1+WAIT_CYCLES cycles; done high in cycle
//   k+2+WAIT_CYCLES. Throughput 1 access per 3+WAIT_CYCLES cycles.
// - Misaligned (addr[1:0]!=0): granted normally, mem_read/mem_write stay 0 throughout, done with err=1,
//   rdata=0.
// - Writes return rdata=0.
// - Valid dropped after grant: access still completes, done pulse still issued.
// - Non-owner port: done/rdata/err stay 0.
// - Simultaneous valid: arbitration per CONFIGURATION.
// - Reset mid-access: access aborted, no done pulse; requester must reissue. A write is performed iff
//   its first ACCESS cycle completed before reset.
// - All 128 words reachable; no out-of-range case at ADDR_W=9.
// CONFIGURATION
// - DMEM_ARB_RR_EN defined: round-robin; on simultaneous valid grant the port != last_grant; last_grant
//   updates on every grant; first contention after reset goes to port 0.
// - DMEM_ARB_RR_EN undefined: fixed priority, port 0 always wins; last_grant logic absent; port 1 can
//   starve while req0_valid is held.
// TESTING
// - Read, WAIT=0: mem[5]=0xDEADBEEF, req0 addr 0x014 -> done0 two cycles after grant edge,
//   rdata0=0xDEADBEEF, mem_read high exactly 1 cycle, err0=0.
// - Write/readback port 1: write 0x12345678 @0x1FC, then read @0x1FC -> mem_write high 1 cycle,
//   rdata1=0x12345678, done0 never pulses.
// - Contention: both valid continuously -> without macro all grants to port 0; with DMEM_ARB_RR_EN
//   grants 0,1,0,1, done spacing 3 cycles.
// - Misaligned: req0 write 0xCAFEF00D @0x013 -> done0 with err0=1, mem_write never 1, mem[4] unchanged.
// - WAIT_CYCLES=3: read @0x000 -> mem_read high 4 cycles, done0 in cycle k+5.
// - Reset: rst_n low during ACCESS -> all outputs 0 immediately, no done pulse; after release a new
//   req1 read completes normally.

Source files
------------

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port arbiter and access sequencer for the 128x32 data memory (optional DMEM_ARB_RR_EN)

module dmem_arbiter #(
    parameter int ADDR_W      = 9,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 0,
    parameter int CNT_W       = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              done0,
    output logic [DATA_W-1:0] rdata0,
    output logic              err0,
    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              done1,
    output logic [DATA_W-1:0] rdata1,
    output logic              err1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arbState_t;

    arbState_t         state;
    arbState_t         nextState;
    logic              owner;
    logic              ownWe;
    logic [ADDR_W-1:0] ownAddr;
    logic [DATA_W-1:0] ownWdata;
    logic [DATA_W-1:0] rdataReg;
    logic [CNT_W-1:0]  cnt;
    logic              anyValid;
    logic              grantPort;
    logic              misaligned;
    logic              firstCycle;

    assign anyValid   = req0_valid | req1_valid;
    assign misaligned = |ownAddr[1:0];
    assign firstCycle = (cnt == CNT_W'(WAIT_CYCLES));

`ifdef DMEM_ARB_RR_EN
    logic lastGrant;

    // On a tie the port that did not win last time is served; a lone request always wins
    assign grantPort = (req0_valid & req1_valid) ? ~lastGrant : req1_valid;

    // Remember the most recently granted port, updated on every grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lastGrant <= 1'b1;
        end else if (state == IDLE && anyValid) begin
            lastGrant <= grantPort;
        end
    end
`else
    // Fixed priority: port 0 wins whenever it is requesting
    assign grantPort = ~req0_valid;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Latch the granted request, run the wait counter and capture read data at the last ACCESS cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner    <= 1'b0;
            ownWe    <= 1'b0;
            ownAddr  <= '0;
            ownWdata <= '0;
            rdataReg <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (anyValid) begin
                        owner    <= grantPort;
                        ownWe    <= grantPort ? req1_we : req0_we;
                        ownAddr  <= grantPort ? req1_addr : req0_addr;
                        ownWdata <= grantPort ? req1_wdata : req0_wdata;
                        rdataReg <= '0;
                        cnt      <= CNT_W'(WAIT_CYCLES);
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        // Writes and misaligned accesses report zero read data
                        rdataReg <= (~ownWe & ~misaligned) ? mem_rdata : '0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state logic plus memory strobes and the per-port completion outputs
    always_comb begin
        nextState = state;
        mem_addr  = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_wdata = '0;
        done0     = 1'b0;
        rdata0    = '0;
        err0      = 1'b0;
        done1     = 1'b0;
        rdata1    = '0;
        err1      = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (anyValid) begin
                    nextState = ACCESS;
                end
            end
            ACCESS: begin
                mem_addr  = ownAddr;
                mem_wdata = ownWe ? ownWdata : '0;
                mem_read  = ~ownWe & ~misaligned;
                // A write strobes only once even when wait states stretch the access
                mem_write = ownWe & ~misaligned & firstCycle;
                if (cnt == '0) begin
                    nextState = RESP;
                end
            end
            RESP: begin
                done0     = ~owner;
                rdata0    = owner ? '0 : rdataReg;
                err0      = ~owner & misaligned;
                done1     = owner;
                rdata1    = owner ? rdataReg : '0;
                err1      = owner & misaligned;
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

endmodule
